// File: rtl/sdp_distram_pkg.sv
// Shared constants and helpers for the multi-read-port distributed RAM.
// Address width is computed here so every file agrees on it.
package sdp_distram_pkg;
    localparam int BYTE_W     = 8;
    localparam int MAX_ADDR_W = 16;

    // One port's address, widened so the write/read match compares equal widths.
    typedef logic [MAX_ADDR_W-1:0] rd_addr_t;

    function automatic int clog2_min1(input int depth);
        return ($clog2(depth) < 1) ? 1 : $clog2(depth);
    endfunction
endpackage

// File: rtl/distram_rd_pipe.sv
// Elastic output pipeline for one read port: N valid/data stages whose bubbles collapse.
// With zero stages it is a straight wire from capture to output.
module distram_rd_pipe #(
    parameter int WIDTH           = 32,
    parameter int OUT_PIPE_STAGES = 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);
    localparam int N = OUT_PIPE_STAGES;

    if (N == 0) begin : g_comb
        logic w_unused;
        assign w_unused = clk ^ rst;
        assign o_valid  = i_valid;
        assign o_ready  = i_ready;
        assign o_data   = i_data;
    end else begin : g_reg
        logic [N-1:0]            r_v;
        logic [N-1:0][WIDTH-1:0] r_d;
        logic [N-1:0]            w_adv;
        logic [N-1:0]            w_vin;
        logic [N-1:0][WIDTH-1:0] w_din;

        // A stage may advance if the one after it is empty or itself advancing.
        always_comb begin
            w_adv      = '0;
            w_adv[N-1] = i_ready;
            for (int i = N-2; i >= 0; i--)
                w_adv[i] = !r_v[i+1] || w_adv[i+1];
        end

        assign o_ready = !r_v[0] || w_adv[0];

        always_comb begin
            w_vin    = '0;
            w_din    = '0;
            w_vin[0] = i_valid && o_ready;
            w_din[0] = i_data;
            for (int i = 1; i < N; i++) begin
                w_vin[i] = r_v[i-1];
                w_din[i] = r_d[i-1];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v <= '0;
                r_d <= '0;
            end else begin
                for (int i = 0; i < N; i++)
                    if (!r_v[i] || w_adv[i]) begin
                        r_v[i] <= w_vin[i];
                        r_d[i] <= w_din[i];
                    end
            end
        end

        assign o_valid = r_v[N-1];
        assign o_data  = r_d[N-1];
    end
endmodule

// File: rtl/sdp_distram_mrp.sv
// Distributed RAM with one byte-enabled write port and NUM_RD independently
// stallable read ports, each with its own elastic output pipeline.
module sdp_distram_mrp
    import sdp_distram_pkg::*;
#(
    parameter int  WIDTH           = 32,
    parameter int  DEPTH           = 32,
    parameter int  NUM_RD          = 2,
    parameter int  OUT_PIPE_STAGES = 1,
    parameter int  WR_BYPASS       = 1,
    localparam int AW              = clog2_min1(DEPTH),
    localparam int NB              = WIDTH / BYTE_W
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [NB-1:0]                wr_be,
    input  logic [AW-1:0]                wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic [NUM_RD-1:0]            rd_valid_i,
    input  logic [NUM_RD-1:0][AW-1:0]    rd_addr_i,
    output logic [NUM_RD-1:0]            rd_ready_o,
    output logic [NUM_RD-1:0]            rd_valid_o,
    output logic [NUM_RD-1:0][WIDTH-1:0] rd_data_o,
    input  logic [NUM_RD-1:0]            rd_ready_i
);
    if (WIDTH < BYTE_W || (WIDTH % BYTE_W) != 0) begin : g_bad_width
        $error("sdp_distram_mrp: WIDTH must be a non-zero multiple of 8");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("sdp_distram_mrp: DEPTH must be at least 2");
    end
    if (NUM_RD < 1) begin : g_bad_nrd
        $error("sdp_distram_mrp: NUM_RD must be at least 1");
    end
    if (OUT_PIPE_STAGES < 0 || AW > MAX_ADDR_W) begin : g_bad_cfg
        $error("sdp_distram_mrp: bad OUT_PIPE_STAGES or DEPTH too large");
    end

    // Storage is deliberately outside the reset domain; it powers up zeroed.
    (* ram_style = "distributed" *)
    logic [WIDTH-1:0] r_mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (wr_en)
            for (int b = 0; b < NB; b++)
                if (wr_be[b])
                    r_mem[wr_addr][b*BYTE_W +: BYTE_W] <= wr_data[b*BYTE_W +: BYTE_W];
    end

    logic [NUM_RD-1:0][WIDTH-1:0] w_cap;

    // Capture overlays only the bytes being written this cycle onto the stored word.
    always_comb begin
        w_cap = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            w_cap[p] = r_mem[rd_addr_i[p]];
            if (WR_BYPASS != 0 && wr_en && rd_addr_t'(rd_addr_i[p]) == rd_addr_t'(wr_addr))
                for (int b = 0; b < NB; b++)
                    if (wr_be[b])
                        w_cap[p][b*BYTE_W +: BYTE_W] = wr_data[b*BYTE_W +: BYTE_W];
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        distram_rd_pipe #(
            .WIDTH           (WIDTH),
            .OUT_PIPE_STAGES (OUT_PIPE_STAGES)
        ) u_pipe (
            .clk     (clk),
            .rst     (rst),
            .i_valid (rd_valid_i[p]),
            .o_ready (rd_ready_o[p]),
            .i_data  (w_cap[p]),
            .o_valid (rd_valid_o[p]),
            .o_data  (rd_data_o[p]),
            .i_ready (rd_ready_i[p])
        );
    end
endmodule

// File: tb/tb_sdp_distram_mrp.sv
// Directed bench: three instances (N=1 bypass, N=2 no-bypass, N=0 bypass) share one write bus.
module tb_sdp_distram_mrp;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic wr_en = 1'b0;
    logic [3:0]  wr_be = '0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;

    logic [1:0] a_vi = '0, a_ri = '1, a_ro, a_vo;
    logic [1:0][4:0]  a_ad = '0;
    logic [1:0][31:0] a_do;
    logic [1:0] b_vi = '0, b_ri = '1, b_ro, b_vo;
    logic [1:0][4:0]  b_ad = '0;
    logic [1:0][31:0] b_do;
    logic [1:0] c_vi = '0, c_ri = '1, c_ro, c_vo;
    logic [1:0][4:0]  c_ad = '0;
    logic [1:0][31:0] c_do;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sdp_distram_mrp #(.OUT_PIPE_STAGES(1), .WR_BYPASS(1)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid_i(a_vi), .rd_addr_i(a_ad), .rd_ready_o(a_ro), .rd_valid_o(a_vo),
        .rd_data_o(a_do), .rd_ready_i(a_ri));
    sdp_distram_mrp #(.OUT_PIPE_STAGES(2), .WR_BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid_i(b_vi), .rd_addr_i(b_ad), .rd_ready_o(b_ro), .rd_valid_o(b_vo),
        .rd_data_o(b_do), .rd_ready_i(b_ri));
    sdp_distram_mrp #(.OUT_PIPE_STAGES(0), .WR_BYPASS(1)) u_c (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid_i(c_vi), .rd_addr_i(c_ad), .rd_ready_o(c_ro), .rd_valid_o(c_vo),
        .rd_data_o(c_do), .rd_ready_i(c_ri));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] ad, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = ad; wr_data = d; wr_be = be;
        step();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_chk++; if ({a_vo, b_vo} !== 4'b0000) begin n_fail++; $display("FAIL rst_valid: got %b want 0000", {a_vo, b_vo}); end
        n_chk++; if ({a_do, b_do} !== '0) begin n_fail++; $display("FAIL rst_data: got %h want 0", {a_do, b_do}); end
        n_chk++; if ({a_ro, b_ro} !== 4'b1111) begin n_fail++; $display("FAIL rst_ready: got %b want 1111", {a_ro, b_ro}); end
        #19 rst = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        wr(5'd5, 32'hDEADBEEF, 4'hF);
        a_ad[0] = 5'd5; a_vi[0] = 1'b1;
        step();
        a_vi[0] = 1'b0;
        n_chk++; if (a_vo[0] !== 1'b1) begin n_fail++; $display("FAIL wr_rd_valid: got %b want 1", a_vo[0]); end
        n_chk++; if (a_do[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_data: got %h want deadbeef", a_do[0]); end
        step();
        n_chk++; if (a_vo[0] !== 1'b0) begin n_fail++; $display("FAIL wr_rd_drop: got %b want 0", a_vo[0]); end
    endtask

    task automatic test_bypass();
        wr(5'd3, 32'h11223344, 4'hF);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hAABBCCDD; wr_be = 4'b0101;
        a_vi[0] = 1'b1; a_ad[0] = 5'd3;
        b_vi[0] = 1'b1; b_ad[0] = 5'd3;
        c_vi[0] = 1'b1; c_ad[0] = 5'd3;
        #1;
        n_chk++; if (c_do[0] !== 32'h11BB33DD) begin n_fail++; $display("FAIL byp_comb: got %h want 11bb33dd", c_do[0]); end
        step();
        wr_en = 1'b0; a_vi[0] = 1'b0; b_vi[0] = 1'b0; c_vi[0] = 1'b0;
        n_chk++; if (a_vo[0] !== 1'b1 || a_do[0] !== 32'h11BB33DD) begin n_fail++; $display("FAIL byp_on: got %b/%h want 1/11bb33dd", a_vo[0], a_do[0]); end
        step();
        n_chk++; if (b_vo[0] !== 1'b1 || b_do[0] !== 32'h11223344) begin n_fail++; $display("FAIL byp_off: got %b/%h want 1/11223344", b_vo[0], b_do[0]); end
        a_vi[0] = 1'b1; a_ad[0] = 5'd3;
        step();
        a_vi[0] = 1'b0;
        n_chk++; if (a_do[0] !== 32'h11BB33DD) begin n_fail++; $display("FAIL byp_later: got %h want 11bb33dd", a_do[0]); end
    endtask

    task automatic test_backpressure();
        int nxt = 0;
        int got = 0;
        logic exp_r;
        for (int i = 0; i < 12; i++) wr(5'(i), 32'(i), 4'hF);
        for (int c = 0; c < 30 && got < 8; c++) begin
            b_vi[1] = (nxt < 8); b_ad[1] = 5'(nxt); b_ri[1] = !(c >= 3 && c <= 6);
            exp_r = !(c >= 3 && c <= 6);
            #3;
            n_chk++; if (b_ro[1] !== exp_r) begin n_fail++; $display("FAIL bp_ready c%0d: got %b want %b", c, b_ro[1], exp_r); end
            if (c >= 3 && c <= 6) begin
                n_chk++; if (b_vo[1] !== 1'b1 || b_do[1] !== 32'd1) begin n_fail++; $display("FAIL bp_hold c%0d: got %b/%h want 1/1", c, b_vo[1], b_do[1]); end
            end
            if (b_vo[1] && b_ri[1]) begin
                n_chk++; if (b_do[1] !== 32'(got)) begin n_fail++; $display("FAIL bp_seq: got %h want %h", b_do[1], got); end
                got++;
            end
            if (b_vi[1] && b_ro[1]) nxt++;
            step();
        end
        n_chk++; if (got !== 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", got); end
        b_vi[1] = 1'b0; b_ri[1] = 1'b1;
        #3;
        n_chk++; if (b_vo[1] !== 1'b0) begin n_fail++; $display("FAIL bp_nodup: got %b want 0", b_vo[1]); end
        step();
    endtask

    task automatic test_independence();
        a_ri[0] = 1'b0; a_vi[0] = 1'b1; a_ad[0] = 5'd5;
        step();
        a_ad[0] = 5'd3;
        for (int k = 0; k < 4; k++) begin
            a_vi[1] = 1'b1; a_ad[1] = 5'(8 + k);
            step();
            n_chk++; if (a_vo[1] !== 1'b1 || a_do[1] !== 32'(8 + k)) begin n_fail++; $display("FAIL ind_p1 k%0d: got %b/%h want 1/%h", k, a_vo[1], a_do[1], 8 + k); end
            n_chk++; if (a_vo[0] !== 1'b1 || a_do[0] !== 32'd5 || a_ro[0] !== 1'b0) begin n_fail++; $display("FAIL ind_p0 k%0d: got %b/%h/%b want 1/5/0", k, a_vo[0], a_do[0], a_ro[0]); end
        end
        a_vi = '0; a_ri = '1;
        step();
        n_chk++; if (a_vo !== 2'b00) begin n_fail++; $display("FAIL ind_drain: got %b want 00", a_vo); end
    endtask

    task automatic test_collision();
        a_vi = 2'b11; a_ad[0] = 5'd7; a_ad[1] = 5'd7;
        step();
        a_vi = '0;
        n_chk++; if (a_vo !== 2'b11 || a_do[0] !== 32'd7 || a_do[1] !== 32'd7) begin n_fail++; $display("FAIL collide: got %b/%h/%h want 11/7/7", a_vo, a_do[0], a_do[1]); end
        step();
    endtask

    task automatic test_async_reset();
        a_ri[0] = 1'b0; a_vi[0] = 1'b1; a_ad[0] = 5'd9;
        b_ri[0] = 1'b0; b_vi[0] = 1'b1; b_ad[0] = 5'd9;
        step();
        step();
        n_chk++; if (b_vo[0] !== 1'b1 || b_do[0] !== 32'd9) begin n_fail++; $display("FAIL ar_pre: got %b/%h want 1/9", b_vo[0], b_do[0]); end
        #2 rst = 1'b1;
        #1;
        n_chk++; if ({a_vo, b_vo} !== 4'b0000) begin n_fail++; $display("FAIL ar_valid: got %b want 0000", {a_vo, b_vo}); end
        n_chk++; if ({a_do, b_do} !== '0) begin n_fail++; $display("FAIL ar_data: got %h want 0", {a_do, b_do}); end
        n_chk++; if ({a_ro, b_ro} !== 4'b1111) begin n_fail++; $display("FAIL ar_ready: got %b want 1111", {a_ro, b_ro}); end
        a_vi = '0; b_vi = '0; a_ri = '1; b_ri = '1;
        #14 rst = 1'b0;
        step();
        a_vi[0] = 1'b1; a_ad[0] = 5'd3;
        step();
        a_vi[0] = 1'b0;
        n_chk++; if (a_vo[0] !== 1'b1 || a_do[0] !== 32'd3) begin n_fail++; $display("FAIL ar_ram: got %b/%h want 1/3", a_vo[0], a_do[0]); end
        step();
    endtask

    task automatic test_comb_mode();
        c_vi[0] = 1'b1; c_ri[0] = 1'b0; c_ad[0] = 5'd2;
        #1;
        n_chk++; if (c_ro[0] !== 1'b0 || c_vo[0] !== 1'b1) begin n_fail++; $display("FAIL n0_hs: got %b/%b want 0/1", c_ro[0], c_vo[0]); end
        n_chk++; if (c_do[0] !== 32'd2) begin n_fail++; $display("FAIL n0_data: got %h want 2", c_do[0]); end
        c_ad[0] = 5'd7; c_ri[0] = 1'b1;
        #1;
        n_chk++; if (c_do[0] !== 32'd7 || c_ro[0] !== 1'b1) begin n_fail++; $display("FAIL n0_follow: got %h/%b want 7/1", c_do[0], c_ro[0]); end
        c_vi = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_backpressure();
        test_independence();
        test_collision();
        test_async_reset();
        test_comb_mode();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
